// File: rtl/hack_rom_loader.sv
// Hack ROM loader: owns the ROM write port, holds the CPU in reset during HPS downloads,
// optionally zero-fills the unused ROM tail, and turns the OSD reset into a timed CPU reset.
// Latency: download word reaches rom_we/rom_addr/rom_din one cycle after ioctl_wr.
// Backpressure: ioctl_wait is raised only while the zero fill runs. With the
// HACK_ROM_ZERO_FILL_EN macro undefined, there is no fill and ioctl_wait stays 0.
module hack_rom_loader #(
  parameter int ADDR_W      = 15,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic              ioctl_wait,
  input  logic              user_reset,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_din,
  output logic              cpu_reset,
  output logic              loaded,
  output logic              overflow,
  output logic [ADDR_W:0]   words_loaded
);

  // Counter only needs to reach HOLD_CYCLES-1; the exit happens on that value.
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W + 1)'(1) << ADDR_W;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2,
    FILL = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
`ifdef HACK_ROM_ZERO_FILL_EN
  logic [ADDR_W:0]  fill_addr;
`endif

  logic [ADDR_W-1:0] word_idx;
  logic              in_range;
  logic [ADDR_W:0]   idx_end;
  logic [ADDR_W:0]   wl_next;

  // Byte address to word index; any bit above the ROM word range marks the write as out of range.
  assign word_idx = ioctl_addr[ADDR_W:1];
  assign in_range = ((ioctl_addr >> (ADDR_W + 1)) == 25'd0);
  assign idx_end  = {1'b0, word_idx} + (ADDR_W + 1)'(1);

  // High-water mark including a write accepted this cycle, so FILL starts past the last word.
  always_comb begin
    wl_next = words_loaded;
    if (ioctl_wr && in_range && (idx_end > words_loaded)) begin
      wl_next = idx_end;
    end
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HOLD;
      hold_cnt     <= '0;
      rom_we       <= 1'b0;
      rom_addr     <= '0;
      rom_din      <= '0;
      cpu_reset    <= 1'b1;
      ioctl_wait   <= 1'b0;
      loaded       <= 1'b0;
      overflow     <= 1'b0;
      words_loaded <= '0;
`ifdef HACK_ROM_ZERO_FILL_EN
      fill_addr    <= '0;
`endif
    end else begin
      rom_we <= 1'b0;
      case (state)
        HOLD: begin
          cpu_reset <= 1'b1;
          if (ioctl_download) begin
            state        <= LOAD;
            words_loaded <= '0;
            overflow     <= 1'b0;
          end else if (user_reset) begin
            // A held request keeps re-arming the hold period.
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        RUN: begin
          if (ioctl_download) begin
            state        <= LOAD;
            cpu_reset    <= 1'b1;
            words_loaded <= '0;
            overflow     <= 1'b0;
          end else if (user_reset) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            cpu_reset <= 1'b1;
          end
        end

        LOAD: begin
          cpu_reset <= 1'b1;
          // A write coincident with the download fall is still committed here.
          if (ioctl_wr) begin
            if (in_range) begin
              rom_we   <= 1'b1;
              rom_addr <= word_idx;
              rom_din  <= ioctl_dout;
            end else begin
              overflow <= 1'b1;
            end
          end
          words_loaded <= wl_next;
          if (!ioctl_download) begin
            loaded <= 1'b1;
`ifdef HACK_ROM_ZERO_FILL_EN
            state      <= FILL;
            fill_addr  <= wl_next;
            ioctl_wait <= 1'b1;
`else
            state    <= HOLD;
            hold_cnt <= '0;
`endif
          end
        end

`ifdef HACK_ROM_ZERO_FILL_EN
        FILL: begin
          cpu_reset <= 1'b1;
          if (ioctl_download) begin
            // New image supersedes the partial fill.
            state        <= LOAD;
            ioctl_wait   <= 1'b0;
            words_loaded <= '0;
            overflow     <= 1'b0;
          end else if (fill_addr == DEPTH) begin
            // Every tail word written (or none needed): release HPS and time the CPU reset.
            state      <= HOLD;
            hold_cnt   <= '0;
            ioctl_wait <= 1'b0;
          end else begin
            rom_we    <= 1'b1;
            rom_addr  <= fill_addr[ADDR_W-1:0];
            rom_din   <= '0;
            fill_addr <= fill_addr + (ADDR_W + 1)'(1);
          end
        end
`endif

        default: begin
          state      <= HOLD;
          hold_cnt   <= '0;
          cpu_reset  <= 1'b1;
          ioctl_wait <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Testbench for hack_rom_loader: reset, timed CPU reset, download table, overflow,
// zero fill (when HACK_ROM_ZERO_FILL_EN is defined), coincident-fall write and fill abort.
// Drives inputs away from the rising edge and samples outputs on the falling edge.
module tb_hack_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        user_reset;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_din;
  logic        cpu_reset;
  logic        loaded;
  logic        overflow;
  logic [15:0] words_loaded;

  int n_cmp = 0;
  int n_bad = 0;

  hack_rom_loader #(.ADDR_W(15), .HOLD_CYCLES(16)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .user_reset     (user_reset),
    .rom_we         (rom_we),
    .rom_addr       (rom_addr),
    .rom_din        (rom_din),
    .cpu_reset      (cpu_reset),
    .loaded         (loaded),
    .overflow       (overflow),
    .words_loaded   (words_loaded)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [24:0] addr;
    logic [15:0] dout;
    logic        exp_we;
    logic [14:0] exp_addr;
    logic [15:0] exp_din;
    logic [15:0] exp_wl;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts consecutive cpu_reset-high samples starting with the current one (bounded).
  task automatic count_high(output int n);
    n = 0;
    while (cpu_reset === 1'b1 && n < 200) begin
      n++;
      @(negedge clk_sys);
    end
  endtask

  int hi_n;
  int low_seen;
  int fill_cnt;
  int seq_err;
  int exp_a;

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    user_reset     = 1'b0;

    //            addr          dout      we    addr     din       wl  ovf
    vecs[0] = '{25'h0000000, 16'hA001, 1'b1, 15'd0, 16'hA001, 16'd1, 1'b0};
    vecs[1] = '{25'h0000002, 16'hB002, 1'b1, 15'd1, 16'hB002, 16'd2, 1'b0};
    vecs[2] = '{25'h0000004, 16'hC003, 1'b1, 15'd2, 16'hC003, 16'd3, 1'b0};
    vecs[3] = '{25'h0000006, 16'hD004, 1'b1, 15'd3, 16'hD004, 16'd4, 1'b0};
    vecs[4] = '{25'h0010000, 16'h1234, 1'b0, 15'd0, 16'h0000, 16'd4, 1'b1};
    vecs[5] = '{25'h0000005, 16'h5555, 1'b1, 15'd2, 16'h5555, 16'd4, 1'b1};

    // Reset values
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_rom_we", rom_we, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_din", rom_din, 0);
    chk("rst_ioctl_wait", ioctl_wait, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_words_loaded", words_loaded, 0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    @(negedge clk_sys);
    count_high(hi_n);
    chk("por_hold_len", hi_n, 16);
    chk("por_run", cpu_reset, 0);

    // One-cycle user_reset pulse in RUN
    @(posedge clk_sys); #1;
    user_reset = 1'b1;
    @(posedge clk_sys); #1;
    user_reset = 1'b0;
    @(negedge clk_sys);
    count_high(hi_n);
    chk("pulse_hold_len", hi_n, 16);

    // user_reset held for many cycles
    @(posedge clk_sys); #1;
    user_reset = 1'b1;
    low_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      if (cpu_reset !== 1'b1) low_seen++;
    end
    @(posedge clk_sys); #1;
    user_reset = 1'b0;
    @(negedge clk_sys);
    chk("held_low_during", low_seen, 0);
    count_high(hi_n);
    chk("held_hold_len", hi_n, 16);

    // Download start; user_reset must be ignored while loading
    ioctl_download = 1'b1;
    user_reset     = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("load_cpu_reset", cpu_reset, 1);
    chk("load_wl0", words_loaded, 0);
    chk("load_wait", ioctl_wait, 0);

    // Download writes from the table
    for (int i = 0; i < 6; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = vecs[i].addr;
      ioctl_dout = vecs[i].dout;
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
      @(negedge clk_sys);
      chk($sformatf("v%0d_we", i), rom_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk($sformatf("v%0d_addr", i), rom_addr, vecs[i].exp_addr);
        chk($sformatf("v%0d_din", i), rom_din, vecs[i].exp_din);
      end
      chk($sformatf("v%0d_wl", i), words_loaded, vecs[i].exp_wl);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].exp_ovf);
      chk($sformatf("v%0d_cpu_reset", i), cpu_reset, 1);
      @(negedge clk_sys);
      chk($sformatf("v%0d_we_pulse", i), rom_we, 0);
    end
    user_reset = 1'b0;

    // Download ends
    ioctl_download = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("exit_loaded", loaded, 1);
`ifdef HACK_ROM_ZERO_FILL_EN
    chk("fill_wait_on", ioctl_wait, 1);
    fill_cnt = 0;
    seq_err  = 0;
    exp_a    = 4;
    for (int i = 0; i < 40000; i++) begin
      if (ioctl_wait !== 1'b1) break;
      if (rom_we === 1'b1) begin
        if (rom_addr !== exp_a[14:0] || rom_din !== 16'h0000) seq_err++;
        exp_a++;
        fill_cnt++;
      end
      @(negedge clk_sys);
    end
    chk("fill_count", fill_cnt, 32764);
    chk("fill_seq_err", seq_err, 0);
    chk("fill_end_wait", ioctl_wait, 0);
    chk("fill_end_we", rom_we, 0);
`else
    chk("nofill_wait", ioctl_wait, 0);
    chk("nofill_we", rom_we, 0);
`endif
    count_high(hi_n);
    chk("post_load_hold_len", hi_n, 16);
    chk("post_load_loaded", loaded, 1);

    // New download clears overflow; write at the top word coincident with the fall
    ioctl_download = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("dl2_ovf_clear", overflow, 0);
    chk("dl2_wl_clear", words_loaded, 0);
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'h000FFFE;
    ioctl_dout     = 16'h7E57;
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("top_we", rom_we, 1);
    chk("top_addr", rom_addr, 15'h7FFF);
    chk("top_din", rom_din, 16'h7E57);
    chk("top_wl", words_loaded, 16'h8000);
`ifdef HACK_ROM_ZERO_FILL_EN
    chk("top_fill_wait", ioctl_wait, 1);
`endif
    @(negedge clk_sys);
    chk("top_no_fill_we", rom_we, 0);
    chk("top_wait_off", ioctl_wait, 0);
    chk("top_in_hold", cpu_reset, 1);
    count_high(hi_n);

`ifdef HACK_ROM_ZERO_FILL_EN
    // Abort a running fill with a new download
    ioctl_download = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'h0000000;
    ioctl_dout     = 16'h0001;
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    repeat (10) @(negedge clk_sys);
    chk("abort_mid_wait", ioctl_wait, 1);
    chk("abort_mid_we", rom_we, 1);
    chk("abort_mid_addr", rom_addr, 15'd9);
    ioctl_download = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("abort_wait_off", ioctl_wait, 0);
    chk("abort_we_off", rom_we, 0);
    chk("abort_wl_clear", words_loaded, 0);
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'h000FFFE;
    ioctl_dout     = 16'h0BAD;
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("abort_top_addr", rom_addr, 15'h7FFF);
    @(negedge clk_sys);
    chk("abort_done_wait", ioctl_wait, 0);
    chk("abort_done_we", rom_we, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
